// File: rtl/dp_regfile_port_arbiter_if.sv
// Requester-side bus of the register-file port arbiter: per-requester
// access request, grant and read return, packed one slice per requester.
interface dp_regfile_port_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int RAM_A_WIDTH = 10,
  parameter int RAM_D_WIDTH = 8
);
  logic [NUM_REQ-1:0]                  req;
  logic [NUM_REQ-1:0]                  we;
  logic [NUM_REQ-1:0][RAM_A_WIDTH-1:0] addr;
  logic [NUM_REQ-1:0][RAM_D_WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]                  gnt;
  logic [NUM_REQ-1:0]                  rvalid;
  logic [NUM_REQ-1:0][RAM_D_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dp_regfile_port_arbiter.sv
// Two-port register-file arbiter with rotating priority, conflict-free port
// pairing, and a clear sequencer that zeroes the file after reset or on clr.

module dp_regfile_port_arbiter_ret #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hit_a_i,
  input  logic          hit_b_i,
  input  logic [DW-1:0] dout_a_i,
  input  logic [DW-1:0] dout_b_i,
  output logic          rvalid_o,
  output logic [DW-1:0] rdata_o
);
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= hit_a_i | hit_b_i;
      if (hit_a_i)      rdata_q <= dout_a_i;
      else if (hit_b_i) rdata_q <= dout_b_i;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
endmodule

module dp_regfile_port_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int RAM_SIZE    = 1024,
  parameter int RAM_A_WIDTH = 10,
  parameter int RAM_D_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  output logic                   init_done,
  dp_regfile_port_arbiter_if.slave rq,
  output logic [RAM_A_WIDTH-1:0] rf_addr_a,
  output logic [RAM_A_WIDTH-1:0] rf_addr_b,
  output logic [RAM_D_WIDTH-1:0] rf_din_a,
  output logic [RAM_D_WIDTH-1:0] rf_din_b,
  output logic                   rf_we_a,
  output logic                   rf_we_b,
  input  logic [RAM_D_WIDTH-1:0] rf_dout_a,
  input  logic [RAM_D_WIDTH-1:0] rf_dout_b
);
  localparam int AW = RAM_A_WIDTH;
  localparam int DW = RAM_D_WIDTH;
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [AW:0] SIZE = (AW+1)'(RAM_SIZE);

  typedef enum logic {INIT, RUN} state_e;

  state_e        state_q;
  logic [AW:0]   cnt_q, cnt_p1, cnt_p2;
  logic [PW-1:0] ptr_q, idx_a, idx_b, scan, rd_idx_a_q, rd_idx_b_q;
  logic          gv_a, gv_b, stop;
  logic          rd_a_q, rd_b_q, init_done_q;
  logic [AW-1:0] rf_addr_a_q, rf_addr_b_q;
  logic [DW-1:0] rf_din_a_q, rf_din_b_q;
  logic          rf_we_a_q, rf_we_b_q;
  logic [NUM_REQ-1:0]         gnt_c, rv;
  logic [NUM_REQ-1:0][DW-1:0] rd;

  assign cnt_p1 = cnt_q + (AW+1)'(1);
  assign cnt_p2 = cnt_q + (AW+1)'(2);

  // Port B may only take a second requester whose access cannot collide with
  // A's; the first collision stops the scan so priority order is preserved.
  always_comb begin
    gv_a  = 1'b0;
    gv_b  = 1'b0;
    stop  = 1'b0;
    idx_a = '0;
    idx_b = '0;
    scan  = '0;
    gnt_c = '0;
    if (state_q == RUN && !clr) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan = ptr_q + PW'(k);
        if (rq.req[scan] && ({1'b0, rq.addr[scan]} < SIZE) && !stop && !gv_b) begin
          if (!gv_a) begin
            gv_a  = 1'b1;
            idx_a = scan;
          end else if (rq.addr[scan] != rq.addr[idx_a] || (!rq.we[scan] && !rq.we[idx_a])) begin
            gv_b  = 1'b1;
            idx_b = scan;
          end else begin
            stop = 1'b1;
          end
        end
      end
      if (gv_a) gnt_c[idx_a] = 1'b1;
      if (gv_b) gnt_c[idx_b] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
      rf_addr_a_q <= '0;
      rf_addr_b_q <= '0;
      rf_din_a_q  <= '0;
      rf_din_b_q  <= '0;
      rf_we_a_q   <= 1'b0;
      rf_we_b_q   <= 1'b0;
      rd_a_q      <= 1'b0;
      rd_b_q      <= 1'b0;
      rd_idx_a_q  <= '0;
      rd_idx_b_q  <= '0;
    end else begin
      case (state_q)
        INIT: begin
          rf_we_a_q   <= 1'b1;
          rf_addr_a_q <= cnt_q[AW-1:0];
          rf_din_a_q  <= '0;
          rf_we_b_q   <= (cnt_p1 < SIZE);
          rf_addr_b_q <= cnt_p1[AW-1:0];
          rf_din_b_q  <= '0;
          rd_a_q      <= 1'b0;
          rd_b_q      <= 1'b0;
          cnt_q       <= cnt_p2;
          if (cnt_p2 >= SIZE) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          rf_we_a_q   <= gv_a & rq.we[idx_a];
          rf_addr_a_q <= gv_a ? rq.addr[idx_a]  : '0;
          rf_din_a_q  <= gv_a ? rq.wdata[idx_a] : '0;
          rf_we_b_q   <= gv_b & rq.we[idx_b];
          rf_addr_b_q <= gv_b ? rq.addr[idx_b]  : '0;
          rf_din_b_q  <= gv_b ? rq.wdata[idx_b] : '0;
          rd_a_q      <= gv_a & ~rq.we[idx_a];
          rd_b_q      <= gv_b & ~rq.we[idx_b];
          rd_idx_a_q  <= idx_a;
          rd_idx_b_q  <= idx_b;
          if (gv_b)      ptr_q <= idx_b + PW'(1);
          else if (gv_a) ptr_q <= idx_a + PW'(1);
          if (clr) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Read returns keep draining through a clr; only rst discards them.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ret
    dp_regfile_port_arbiter_ret #(.DW(DW)) u_ret (
      .clk      (clk),
      .rst      (rst),
      .hit_a_i  (rd_a_q && rd_idx_a_q == PW'(g)),
      .hit_b_i  (rd_b_q && rd_idx_b_q == PW'(g)),
      .dout_a_i (rf_dout_a),
      .dout_b_i (rf_dout_b),
      .rvalid_o (rv[g]),
      .rdata_o  (rd[g])
    );
  end

  assign rq.gnt     = gnt_c;
  assign rq.rvalid  = rv;
  assign rq.rdata   = rd;
  assign init_done  = init_done_q;
  assign rf_addr_a  = rf_addr_a_q;
  assign rf_addr_b  = rf_addr_b_q;
  assign rf_din_a   = rf_din_a_q;
  assign rf_din_b   = rf_din_b_q;
  assign rf_we_a    = rf_we_a_q;
  assign rf_we_b    = rf_we_b_q;
endmodule

// File: tb/tb_dp_regfile_port_arbiter.sv
// Directed bench: dual-port file model plus per-scenario tasks with
// hand-computed grants, latencies and read data.
module tb_dp_regfile_port_arbiter;
  localparam int NR = 4, AW = 10, DW = 8, RS = 1024;

  logic clk = 1'b0, rst = 1'b0, clr = 1'b0, fill = 1'b0;
  logic init_done;
  logic [AW-1:0] rf_addr_a, rf_addr_b;
  logic [DW-1:0] rf_din_a, rf_din_b, rf_dout_a, rf_dout_b;
  logic rf_we_a, rf_we_b;
  logic [DW-1:0] mem [0:RS-1];
  int n_cmp = 0, n_err = 0;

  dp_regfile_port_arbiter_if #(.NUM_REQ(NR), .RAM_A_WIDTH(AW), .RAM_D_WIDTH(DW)) bus ();

  dp_regfile_port_arbiter #(.NUM_REQ(NR), .RAM_SIZE(RS), .RAM_A_WIDTH(AW), .RAM_D_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .init_done(init_done), .rq(bus),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_din_a(rf_din_a), .rf_din_b(rf_din_b),
    .rf_we_a(rf_we_a), .rf_we_b(rf_we_b), .rf_dout_a(rf_dout_a), .rf_dout_b(rf_dout_b)
  );

  always #5 clk = ~clk;

  // Register file model: synchronous write, combinational read; seeded with garbage.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < RS; i++) mem[i] <= DW'(i) ^ 8'hA5 | 8'h01;
    end else begin
      if (rf_we_a) mem[rf_addr_a] <= rf_din_a;
      if (rf_we_b) mem[rf_addr_b] <= rf_din_b;
    end
  end
  assign rf_dout_a = mem[rf_addr_a];
  assign rf_dout_b = mem[rf_addr_b];

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic idle();
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i] = 1'b1; bus.we[i] = w; bus.addr[i] = a; bus.wdata[i] = d;
  endtask

  task automatic test_reset();
    int rise; bit bad; int nz;
    rst = 1'b0; clr = 1'b0; idle(); fill = 1'b1; tick(); fill = 1'b0; tick();
    @(negedge clk);
    n_cmp++;
    if (init_done !== 1'b0 || bus.gnt !== '0 || bus.rvalid !== '0 || rf_we_a !== 1'b0 || rf_we_b !== 1'b0 ||
        rf_addr_a !== '0 || rf_addr_b !== '0 || rf_din_a !== '0 || rf_din_b !== '0 || bus.rdata !== '0) begin
      n_err++;
      $display("FAIL reset_vals: init_done=%b gnt=%b rvalid=%b we=%b%b addr=%0d/%0d rdata=%h, required all zero",
               init_done, bus.gnt, bus.rvalid, rf_we_a, rf_we_b, rf_addr_a, rf_addr_b, bus.rdata);
    end
    rst = 1'b1;
    rise = 0; bad = 1'b0;
    for (int k = 1; k <= 600 && rise == 0; k++) begin
      tick();
      if (init_done === 1'b1) rise = k;
      if (k <= 512 && (rf_we_a !== 1'b1 || rf_addr_a !== AW'(2*(k-1)) || rf_we_b !== 1'b1 || rf_addr_b !== AW'(2*k-1)))
        bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin n_err++; $display("FAIL init_seq: address/we sequence wrong, required 0/1,2/3..1022/1023 all enabled"); end
    n_cmp++;
    if (rise !== 512) begin n_err++; $display("FAIL init_done_rise: rose after %0d cycles, required 512", rise); end
    tick();
    n_cmp++;
    if (rf_we_a !== 1'b0 || rf_we_b !== 1'b0) begin
      n_err++; $display("FAIL idle_after_init: we=%b%b, required 00", rf_we_a, rf_we_b);
    end
    nz = 0;
    for (int i = 0; i < RS; i++) if (mem[i] !== '0) nz++;
    n_cmp++;
    if (nz != 0) begin n_err++; $display("FAIL mem_cleared: %0d nonzero words, required 0", nz); end
  endtask

  // ptr 0: req0 reads 1023, req1 reads 0 -> both granted, both return 0.
  task automatic test_cleared_reads();
    idle(); set_req(0, 1'b0, 10'd1023, '0); set_req(1, 1'b0, 10'd0, '0);
    @(negedge clk);
    n_cmp++;
    if (bus.gnt !== 4'b0011) begin n_err++; $display("FAIL clr_read_gnt: gnt=%b required 0011", bus.gnt); end
    tick(); idle(); tick();
    @(negedge clk);
    n_cmp++;
    if (bus.rvalid !== 4'b0011 || bus.rdata[0] !== 8'h00 || bus.rdata[1] !== 8'h00) begin
      n_err++; $display("FAIL clr_read_data: rvalid=%b rdata0=%h rdata1=%h, required 0011 00 00",
                        bus.rvalid, bus.rdata[0], bus.rdata[1]);
    end
    tick();
  endtask

  // ptr 2: four writes to 100..103 take two cycles, (2,3) then (0,1).
  task automatic test_write_seq();
    idle();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(100 + i), DW'(8'h10 + i));
    @(negedge clk);
    n_cmp++;
    if (bus.gnt !== 4'b1100) begin n_err++; $display("FAIL wr_gnt0: gnt=%b required 1100", bus.gnt); end
    tick(); bus.req[2] = 1'b0; bus.req[3] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.gnt !== 4'b0011) begin n_err++; $display("FAIL wr_gnt1: gnt=%b required 0011", bus.gnt); end
    tick(); idle(); tick();
    @(negedge clk);
    n_cmp++;
    if (bus.rvalid !== 4'b0000) begin n_err++; $display("FAIL wr_no_rvalid: rvalid=%b required 0000", bus.rvalid); end
    tick();
  endtask

  // ptr 2: continuous reads rotate (2,3),(0,1),...; rvalid two cycles after gnt.
  task automatic test_rotate();
    logic [NR-1:0] hist [6];
    logic [NR-1:0] exp;
    bit bad;
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c < 4) for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(100 + i), '0);
      @(negedge clk);
      exp = (c >= 4) ? 4'b0000 : ((c % 2 == 0) ? 4'b1100 : 4'b0011);
      hist[c] = exp;
      n_cmp++;
      if (bus.gnt !== exp) begin n_err++; $display("FAIL rot_gnt c%0d: gnt=%b required %b", c, bus.gnt, exp); end
      exp = (c >= 2) ? hist[c-2] : 4'b0000;
      bad = (bus.rvalid !== exp);
      for (int i = 0; i < NR; i++) if (exp[i] && bus.rdata[i] !== DW'(8'h10 + i)) bad = 1'b1;
      n_cmp++;
      if (bad) begin
        n_err++; $display("FAIL rot_ret c%0d: rvalid=%b rdata=%h required rvalid %b data 10+i", c, bus.rvalid, bus.rdata, exp);
      end
      tick();
    end
    idle();
  endtask

  // ptr 2: req0 writes 7 and req1 reads 7 together -> req1 waits a cycle, sees 5A.
  task automatic test_raw_conflict();
    idle(); set_req(0, 1'b1, 10'd7, 8'h5A); set_req(1, 1'b0, 10'd7, '0);
    @(negedge clk);
    n_cmp++;
    if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL raw_gnt0: gnt=%b required 0001", bus.gnt); end
    tick();
    n_cmp++;
    if (rf_we_a !== 1'b1 || rf_addr_a !== 10'd7 || rf_din_a !== 8'h5A || rf_we_b !== 1'b0) begin
      n_err++; $display("FAIL raw_port: we_a=%b addr_a=%0d din_a=%h we_b=%b required 1 7 5a 0",
                        rf_we_a, rf_addr_a, rf_din_a, rf_we_b);
    end
    bus.req[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL raw_gnt1: gnt=%b required 0010", bus.gnt); end
    tick(); idle();
    @(negedge clk);
    n_cmp++;
    if (bus.rvalid !== 4'b0000) begin n_err++; $display("FAIL raw_early: rvalid=%b required 0000", bus.rvalid); end
    tick();
    @(negedge clk);
    n_cmp++;
    if (bus.rvalid !== 4'b0010 || bus.rdata[1] !== 8'h5A) begin
      n_err++; $display("FAIL raw_data: rvalid=%b rdata1=%h required 0010 5a", bus.rvalid, bus.rdata[1]);
    end
    tick();
  endtask

  // ptr 2: req2 writes C3 to 9, then req2/req3 read 9 together (ptr 3 -> A=3, B=2).
  task automatic test_same_read();
    idle(); set_req(2, 1'b1, 10'd9, 8'hC3);
    @(negedge clk);
    n_cmp++;
    if (bus.gnt !== 4'b0100) begin n_err++; $display("FAIL same_wr_gnt: gnt=%b required 0100", bus.gnt); end
    tick(); idle(); tick();
    set_req(2, 1'b0, 10'd9, '0); set_req(3, 1'b0, 10'd9, '0);
    @(negedge clk);
    n_cmp++;
    if (bus.gnt !== 4'b1100) begin n_err++; $display("FAIL same_rd_gnt: gnt=%b required 1100", bus.gnt); end
    tick(); idle(); tick();
    @(negedge clk);
    n_cmp++;
    if (bus.rvalid !== 4'b1100 || bus.rdata[2] !== 8'hC3 || bus.rdata[3] !== 8'hC3) begin
      n_err++; $display("FAIL same_rd_data: rvalid=%b rdata2=%h rdata3=%h required 1100 c3 c3",
                        bus.rvalid, bus.rdata[2], bus.rdata[3]);
    end
    tick();
  endtask

  // ptr 3: reads in flight across clr; clr mid-INIT ignored; memory re-cleared.
  task automatic test_clr();
    int low; bit gbad; int nz;
    idle(); set_req(0, 1'b0, 10'd100, '0); set_req(1, 1'b0, 10'd101, '0);
    @(negedge clk);
    n_cmp++;
    if (bus.gnt !== 4'b0011) begin n_err++; $display("FAIL clr_pre_gnt: gnt=%b required 0011", bus.gnt); end
    tick(); clr = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.gnt !== 4'b0000 || init_done !== 1'b1) begin
      n_err++; $display("FAIL clr_cycle: gnt=%b init_done=%b required 0000 1", bus.gnt, init_done);
    end
    tick(); clr = 1'b0; idle(); set_req(0, 1'b0, 10'd100, '0);
    @(negedge clk);
    n_cmp++;
    if (bus.rvalid !== 4'b0011 || bus.rdata[0] !== 8'h10 || bus.rdata[1] !== 8'h11 || init_done !== 1'b0) begin
      n_err++; $display("FAIL clr_inflight: rvalid=%b rdata0=%h rdata1=%h init_done=%b required 0011 10 11 0",
                        bus.rvalid, bus.rdata[0], bus.rdata[1], init_done);
    end
    low = 1; gbad = (bus.gnt !== '0);
    for (int n = 0; n < 2000; n++) begin
      tick();
      clr = (n == 100);
      @(negedge clk);
      if (init_done === 1'b1) break;
      low++;
      if (bus.gnt !== '0) gbad = 1'b1;
    end
    clr = 1'b0;
    n_cmp++;
    if (low !== 512) begin n_err++; $display("FAIL clr_init_len: init_done low %0d cycles, required 512", low); end
    n_cmp++;
    if (gbad) begin n_err++; $display("FAIL clr_init_gnt: grant seen during INIT, required none"); end
    n_cmp++;
    if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL clr_post_gnt: gnt=%b required 0001", bus.gnt); end
    tick(); idle(); tick();
    @(negedge clk);
    n_cmp++;
    if (bus.rvalid !== 4'b0001 || bus.rdata[0] !== 8'h00) begin
      n_err++; $display("FAIL clr_post_data: rvalid=%b rdata0=%h required 0001 00", bus.rvalid, bus.rdata[0]);
    end
    nz = 0;
    for (int i = 0; i < RS; i++) if (mem[i] !== '0) nz++;
    n_cmp++;
    if (nz != 0) begin n_err++; $display("FAIL clr_mem: %0d nonzero words, required 0", nz); end
    tick();
  endtask

  // ptr 1: rst the cycle after a read grant drops the read and restarts INIT.
  task automatic test_rst_mid();
    idle(); set_req(1, 1'b0, 10'd100, '0);
    @(negedge clk);
    n_cmp++;
    if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL rst_pre_gnt: gnt=%b required 0010", bus.gnt); end
    tick(); rst = 1'b0; idle(); #1;
    n_cmp++;
    if (bus.rvalid !== '0 || rf_we_a !== 1'b0 || rf_addr_a !== '0 || init_done !== 1'b0 || bus.gnt !== '0) begin
      n_err++; $display("FAIL rst_async: rvalid=%b we_a=%b addr_a=%0d init_done=%b gnt=%b required all 0",
                        bus.rvalid, rf_we_a, rf_addr_a, init_done, bus.gnt);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (bus.rvalid !== '0 || bus.rdata !== '0) begin
      n_err++; $display("FAIL rst_drop: rvalid=%b rdata=%h required 0 0", bus.rvalid, bus.rdata);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (rf_we_a !== 1'b1 || rf_addr_a !== 10'd0 || rf_we_b !== 1'b1 || rf_addr_b !== 10'd1 || init_done !== 1'b0) begin
      n_err++; $display("FAIL rst_restart: we=%b%b addr=%0d/%0d init_done=%b required 11 0/1 0",
                        rf_we_a, rf_we_b, rf_addr_a, rf_addr_b, init_done);
    end
    tick();
    n_cmp++;
    if (rf_addr_a !== 10'd2 || rf_addr_b !== 10'd3) begin
      n_err++; $display("FAIL rst_restart2: addr=%0d/%0d required 2/3", rf_addr_a, rf_addr_b);
    end
  endtask

  initial begin
    test_reset();
    test_cleared_reads();
    test_write_seq();
    test_rotate();
    test_raw_conflict();
    test_same_read();
    test_clr();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/dp_regfile_port_arbiter.md
Name: dp_regfile_port_arbiter

Overview:
- Controller and arbiter in front of the warp scheduler's dual-port register file.
- Shares the file's two ports (A, B) among NUM_REQ requesters with rotating priority.
- Never pairs conflicting accesses on the two ports.
- Clears the whole file after reset or on demand, because the file's own reset does not initialise storage.

Parameters:
- NUM_REQ, 4: number of requesters (power of 2, ≥2).
- RAM_SIZE, 1024: register file depth in words.
- RAM_A_WIDTH, 10: address width.
- RAM_D_WIDTH, 8: data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- clr  in  1  single-cycle pulse: re-clear the register file.
- init_done  out  1  high when the file is cleared and the block is accepting requests.
- req  in  NUM_REQ  per-requester access request.
- we  in  NUM_REQ  per-requester write enable (0 = read).
- addr  in  NUM_REQ*RAM_A_WIDTH  per-requester address; requester i uses slice i.
- wdata  in  NUM_REQ*RAM_D_WIDTH  per-requester write data.
- gnt  out  NUM_REQ  combinational grant, one-hot per port, at most 2 bits set.
- rvalid  out  NUM_REQ  registered read-return strobe.
- rdata  out  NUM_REQ*RAM_D_WIDTH  registered read data; requester i uses slice i.
- rf_addr_a, rf_addr_b  out  RAM_A_WIDTH  registered file port addresses.
- rf_din_a, rf_din_b  out  RAM_D_WIDTH  registered file write data.
- rf_we_a, rf_we_b  out  1  registered file write enables.
- rf_dout_a, rf_dout_b  in  RAM_D_WIDTH  file read data (combinational from rf_addr_*).

Behaviour:
- Reset values (rst low): state INIT, init counter 0, priority pointer 0; every rf_* output, rvalid, rdata and init_done is 0. gnt is 0 while not in RUN.
- FSM states:
  - INIT: port A writes 0 to address cnt, port B writes 0 to cnt+1. rf_we_b is 0 if cnt+1 ≥ RAM_SIZE. cnt increments by 2 each cycle.
  - INIT → RUN when cnt+2 ≥ RAM_SIZE, after that cycle's writes are loaded. INIT lasts ceil(RAM_SIZE/2) cycles.
  - RUN: init_done=1 and arbitration is active. On clr=1: gnt=0 in that cycle, next state INIT, cnt=0, init_done drops next cycle.
  - clr while in INIT: ignored.
  - rst asserted mid-operation: immediate return to reset values; in-flight reads are discarded with no rvalid.
- Arbitration (RUN, combinational):
  - Scan requesters starting at the priority pointer, wrapping mod NUM_REQ.
  - The first requester with req=1 and addr < RAM_SIZE is granted port A.
  - The next such requester is granted port B only if its address differs from A's, or both accesses are reads. Otherwise it and all later requesters wait.
  - Requests with addr ≥ RAM_SIZE are never granted and stay pending; this is a requester error.
  - Pointer update: when any grant is given, pointer ← (index of the last granted requester + 1) mod NUM_REQ. With no grants it is unchanged.
- Pipeline:
  - Grant in cycle T: the granted fields load into the rf_* registers at the end of T. Idle ports load we=0, addr=0.
  - The file sees the access in T+1. Writes commit at the end of T+1.
  - Reads: rf_dout sampled at the end of T+1 into the granted requester's rdata slice, with rvalid=1 for exactly one cycle, T+2.
  - A requester may hold req high; it is re-arbitrated every cycle, each grant is one access, and responses stay in order.
- Hazards:
  - Same-address read/write never shares a cycle, so the file's cross-port forwarding paths are never exercised.
  - Read-after-write from separate cycles sees the new data, since the write commits before the later read is sampled.
- Widths: cnt is RAM_A_WIDTH+1 bits so the comparison cannot wrap. The pointer is log2(NUM_REQ) bits and wraps naturally.

Test Plan:
- Reset then idle → init_done rises exactly 512 cycles after rst deasserts (RAM_SIZE=1024). During INIT, rf_we_a/b=1 with addresses 0/1, 2/3 … 1022/1023. Afterwards all reads return 0.
- All 4 requesters read distinct addresses continuously → grants rotate (0,1), (2,3), (0,1), …. Each gets rvalid 2 cycles after its gnt with the correct data.
- Req0 writes 0x5A to addr 7 while req1 reads addr 7 in the same cycle → only req0 is granted. req1 is granted next cycle and its rdata is 0x5A.
- Req2 and req3 both read addr 9 → both granted in one cycle, and both rdata slices equal the stored value.
- clr pulsed in RUN with reads in flight → in-flight rvalids still delivered, gnt=0 from the clr cycle, init_done low for 512 cycles, then memory reads 0.
- rst asserted the cycle after a read grant → no rvalid, all outputs 0, INIT restarts from address 0.
